instr_feeder: RTL and testbench
===============================

# instr_feeder

Program sequencer that supplies instruction and operand words to the processor controller over the 10-bit external data bus. It holds a small program memory that the host loads while the block is idle. Once started, it drives the word at the program pointer whenever the controller asserts `Ext`, and advances on each consumed word. When the program runs out, or in single-step pause, it feeds a NOP word so the controller retires harmlessly. It also reports progress, completion and operand-underrun errors.

## Interface
- `DEPTH`, 16: program memory words; power of two, 2..256.
- `AW`, $clog2(DEPTH): address width (derived; do not override).
- `NOP_WORD`, 10'b0000000010: word driven when not feeding program; IR[1:0]=10, which the controller clears at timestep 1.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `prog_we` in 1: program write strobe; honoured only in IDLE.
- `prog_addr` in AW: program write address.
- `prog_wdata` in 10: program write data.
- `prog_len` in AW+1: number of valid words, 0..DEPTH; sampled on start.
- `run` in 1: level; a rising into RUN occurs when high in IDLE.
- `step_en` in 1: single-step mode; sampled on start.
- `step` in 1: one-cycle pulse; releases one instruction in PAUSE.
- `IRin` in 1: controller instruction-register load (marks an opcode fetch).
- `Ext` in 1: controller is reading the external bus this cycle.
- `Clr` in 1: controller timestep clear (instruction retired).
- `data` out 10: external data bus word.
- `pc` out AW+1: program pointer.
- `busy` out 1: state is RUN, PAUSE or DRAIN.
- `done` out 1: state is DONE.
- `err` out 1: sticky operand-underrun flag; clears on next start.
- `retired` out 16: count of retired program instructions; wraps at 0xFFFF→0.

## Operation
- States:
  - IDLE: program writes enabled; `data`=NOP_WORD.
  - RUN: feeding program words.
  - PAUSE: step mode, waiting for `step`; feeds NOP.
  - DRAIN: pointer exhausted, last instruction in flight; feeds NOP.
  - DONE: program finished; feeds NOP.
- Start: IDLE & `run` → RUN. Latch `len`=prog_len and `step_mode`=step_en; set `pc`=0, `err`=0, `retired`=0. If prog_len=0, go directly to DONE.
- `data` is combinational: in RUN it is mem[pc] when pc<len, else 0. All other states drive NOP_WORD.
- Consumption is any RUN cycle with `Ext`=1; `pc` increments at that edge.
  - `IRin`=1 is an opcode fetch: set `inflight`.
  - `IRin`=0 is an operand read (LOAD operand word).
- Operand read with pc=len: drive 0, set `err`, pc does not advance.
- `Clr` with `inflight`=1: `retired`++, clear `inflight`. `Clr` with `inflight`=0 (NOP retire) is ignored.
- RUN transitions after a `Clr` of a program instruction:
  - pc=len → DONE.
  - else if `step_mode` → PAUSE.
  - else stay in RUN.
- RUN transition on an opcode fetch that makes pc=len: → DRAIN. DRAIN → DONE on the next `Clr`.
- PAUSE → RUN on `step`. A NOP already fetched in PAUSE retires silently.
- DONE → IDLE when `run`=0.
- `run` deassert in RUN, PAUSE or DRAIN has no effect. A program always completes; only `rst_n` aborts it.
- Program memory is not reset; contents persist across runs and resets.

## Timing
- Reset values: state IDLE, `pc`=0, `busy`=0, `done`=0, `err`=0, `retired`=0, `inflight`=0, `data`=NOP_WORD.
- Zero-latency read: `data` is valid in the same cycle `Ext` rises. Controller timestep 0 fetch and LOAD timestep 1 operand read both rely on this.
- LOAD timestep 1 has `Ext` and `Clr` together. The operand is consumed and the instruction retires on the same edge; apply the pc advance and the retire/transition rules in that order.
- ALU and immediate instructions: `Ext` is high only at timestep 0, so exactly one word is consumed per instruction.
- A `prog_we` outside IDLE is dropped with no side effect. A `prog_we` in the start cycle is written; start still proceeds.
- `rst_n` low mid-run: all state returns to reset values asynchronously, and `data` is NOP_WORD immediately.

## Test plan
- Reset mid-RUN (pc=3, retired=2) → `data`=0x002, pc=0, retired=0, busy=0 during reset and after release.
- Program {0x040 (LOAD R1), 0x155}, len=2, run → timestep 0 `data`=0x040; timestep 1 `data`=0x155 with Clr. Then DONE, pc=2, retired=1, err=0.
- Program {0x008 (ALU, R0,R0), 0x048}, len=2 → pc advances only on Ext cycles (0,1,2). Two retires; DRAIN after the second fetch, then DONE; retired=2.
- len=1, program {0x040} → operand cycle `data`=0, err=1, pc stays 1. DONE after Clr.
- In RUN, `prog_we` to addr 0 with 0x3FF → mem[0] unchanged on next run.
- step_en=1, 2-instruction program → after the first retire, PAUSE feeds 0x002 with retired=1. A `step` pulse fetches instruction 2, then DONE, retired=2.

Source files
------------

// File: rtl/instr_feeder.sv
// Program sequencer feeding instruction/operand words onto the controller's
// 10-bit external bus, with progress, completion and underrun reporting.
module instr_feeder #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter logic [9:0]  NOP_WORD = 10'b0000000010
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [9:0]    prog_wdata,
  input  logic [AW:0]   prog_len,
  input  logic          run,
  input  logic          step_en,
  input  logic          step,
  input  logic          IRin,
  input  logic          Ext,
  input  logic          Clr,
  output logic [9:0]    data,
  output logic [AW:0]   pc,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [15:0]   retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [AW:0] pc_q, pc_d;
  logic [AW:0] len_q, len_d;
  logic        step_mode_q, step_mode_d;
  logic        err_q, err_d;
  logic        inflight_q, inflight_d;
  logic [15:0] retired_q, retired_d;
  logic [9:0]  mem_q [DEPTH];

  logic        in_prog;
  logic        underrun;
  logic        retire;

  // Program memory: host writes land only while idle; contents survive reset
  always_ff @(posedge clk) begin
    if (prog_we && state_q == S_IDLE) begin
      mem_q[prog_addr] <= prog_wdata;
    end
  end

  // Sequencer state register with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      len_q       <= '0;
      step_mode_q <= 1'b0;
      err_q       <= 1'b0;
      inflight_q  <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      len_q       <= len_d;
      step_mode_q <= step_mode_d;
      err_q       <= err_d;
      inflight_q  <= inflight_d;
      retired_q   <= retired_d;
    end
  end

  // Next-state, pointer/retire bookkeeping and bus word selection
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    len_d       = len_q;
    step_mode_d = step_mode_q;
    err_d       = err_q;
    inflight_d  = inflight_q;
    retired_d   = retired_q;
    data        = NOP_WORD;

    in_prog  = (pc_q < len_q);
    // An operand read past the end also happens in DRAIN (a LOAD whose opcode
    // was the last word): it gets 0 and flags the underrun, not a NOP.
    underrun = Ext && !IRin && !in_prog && (state_q == S_RUN || state_q == S_DRAIN);
    retire   = Clr && inflight_q;

    if (underrun) begin
      data  = '0;
      err_d = 1'b1;
    end
    if (retire) begin
      retired_d  = retired_q + 16'd1;
      inflight_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          len_d       = prog_len;
          step_mode_d = step_en;
          pc_d        = '0;
          err_d       = 1'b0;
          retired_d   = '0;
          inflight_d  = 1'b0;
          state_d     = (prog_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        data = in_prog ? mem_q[pc_q[AW-1:0]] : '0;
        if (Ext && in_prog) begin
          pc_d = pc_q + 1'b1;
        end
        if (Ext && IRin) begin
          inflight_d = 1'b1;
          if (pc_d == len_q) begin
            state_d = S_DRAIN;
          end
        end
        // Retire is evaluated against the already-advanced pointer so a LOAD's
        // operand read and retire on the same edge finish the program.
        if (retire) begin
          if (pc_d == len_q) begin
            state_d = S_DONE;
          end else if (step_mode_q) begin
            state_d = S_PAUSE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_PAUSE: begin
        if (step) begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (Clr) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!run) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pc      = pc_q;
  assign err     = err_q;
  assign retired = retired_q;
  assign done    = (state_q == S_DONE);
  assign busy    = (state_q == S_RUN) || (state_q == S_PAUSE) || (state_q == S_DRAIN);

endmodule

// File: tb/tb_instr_feeder.sv
// Scoreboard bench for instr_feeder: the stimulus side plays the processor
// controller and a program-level model; a monitor compares bus and status.
module tb_instr_feeder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam logic [9:0]  NOP   = 10'h002;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [9:0]    prog_wdata = '0;
  logic [AW:0]   prog_len = '0;
  logic          run = 1'b0;
  logic          step_en = 1'b0;
  logic          step = 1'b0;
  logic          IRin = 1'b0;
  logic          Ext = 1'b0;
  logic          Clr = 1'b0;
  logic [9:0]    data;
  logic [AW:0]   pc;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   retired;

  instr_feeder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .prog_len(prog_len), .run(run), .step_en(step_en),
    .step(step), .IRin(IRin), .Ext(Ext), .Clr(Clr), .data(data), .pc(pc),
    .busy(busy), .done(done), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW:0] pc;
    logic [15:0] ret;
    logic        err;
    logic        done;
    logic        busy;
    logic        chk_nop;
  } stat_t;

  logic [9:0] exp_q [$];
  stat_t      stat_q [$];
  string      name_q [$];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          fin = 1'b0;
  bit          fin_done = 1'b0;

  // Program-level model
  logic [9:0]  model_mem [DEPTH];
  int unsigned m_k, m_ret;
  logic        m_err;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
    end
  endtask

  stat_t      mon_s;
  string      mon_n;
  logic [9:0] mon_w;

  // Monitor: the only process that compares
  always @(negedge clk) begin
    if (rst_n && Ext) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL bus_read: unexpected Ext read, data=%h expected no read", data);
      end else begin
        mon_w = exp_q.pop_front();
        cmp("bus", "data", {22'd0, data}, {22'd0, mon_w});
      end
    end
    if (stat_q.size() > 0) begin
      mon_s = stat_q.pop_front();
      mon_n = name_q.pop_front();
      cmp(mon_n, "pc", {27'd0, pc}, {27'd0, mon_s.pc});
      cmp(mon_n, "retired", {16'd0, retired}, {16'd0, mon_s.ret});
      cmp(mon_n, "err", {31'd0, err}, {31'd0, mon_s.err});
      cmp(mon_n, "done", {31'd0, done}, {31'd0, mon_s.done});
      cmp(mon_n, "busy", {31'd0, busy}, {31'd0, mon_s.busy});
      if (mon_s.chk_nop && !Ext) cmp(mon_n, "nop_bus", {22'd0, data}, {22'd0, NOP});
    end
    if (fin && !fin_done) begin
      n_vec++;
      if (exp_q.size() != 0 || stat_q.size() != 0) begin
        n_err++;
        $display("FAIL drain: %0d data and %0d status expectations left, required 0",
                 exp_q.size(), stat_q.size());
      end
      fin_done = 1'b1;
    end
  end

  task automatic push_stat(input string nm, input bit d, input bit b, input bit nop);
    stat_t s;
    s.pc = m_k[AW:0];
    s.ret = m_ret[15:0];
    s.err = m_err;
    s.done = d;
    s.busy = b;
    s.chk_nop = nop;
    stat_q.push_back(s);
    name_q.push_back(nm);
  endtask

  task automatic ctl(input logic e, input logic ir, input logic c);
    Ext = e; IRin = ir; Clr = c;
    @(posedge clk);
    #1;
    Ext = 1'b0; IRin = 1'b0; Clr = 1'b0;
  endtask

  task automatic write_word(input int unsigned a, input logic [9:0] w);
    prog_we = 1'b1; prog_addr = a[AW-1:0]; prog_wdata = w;
    ctl(0, 0, 0);
    prog_we = 1'b0;
    model_mem[a] = w;
  endtask

  // A NOP fetched and retired while the feeder is not supplying program words
  task automatic nop_exec();
    exp_q.push_back(NOP);
    ctl(1, 1, 0);
    ctl(0, 0, 1);
  endtask

  // One program instruction: opcode fetch, then operand read + retire (LOAD)
  // or a few internal cycles and a retire (ALU/immediate)
  task automatic prog_instr(input bit is_load, input int unsigned len);
    exp_q.push_back(model_mem[m_k]);
    m_k++;
    ctl(1, 1, 0);
    push_stat("fetch", 0, 1, 0);
    if (is_load) begin
      if (m_k < len) begin
        exp_q.push_back(model_mem[m_k]);
        m_k++;
      end else begin
        exp_q.push_back(10'h000);
        m_err = 1'b1;
      end
      ctl(1, 0, 1);
    end else begin
      repeat ($urandom_range(0, 2)) ctl(0, 0, 0);
      ctl(0, 0, 1);
    end
    m_ret++;
  endtask

  task automatic run_prog(input int unsigned len, input bit smode, input int unsigned load_pct, input bit start_wr);
    int unsigned a;
    logic [9:0]  w;
    m_k = 0; m_ret = 0; m_err = 1'b0;
    if (start_wr && $urandom_range(0, 1) == 1) begin
      a = $urandom_range(0, DEPTH - 1);
      w = 10'($urandom);
      prog_we = 1'b1; prog_addr = a[AW-1:0]; prog_wdata = w;
      model_mem[a] = w;
    end
    prog_len = len[AW:0]; step_en = smode; run = 1'b1;
    ctl(0, 0, 0);
    prog_we = 1'b0;
    if (len == 0) push_stat("start_empty", 1, 0, 1);
    else push_stat("start", 0, 1, 0);
    run = ($urandom_range(0, 1) == 1);
    // Write attempt outside IDLE must be dropped
    prog_we = 1'b1; prog_addr = '0; prog_wdata = 10'h3FF;
    ctl(0, 0, 0);
    prog_we = 1'b0;
    while (m_k < len) begin
      if (smode && m_ret > 0) begin
        nop_exec();
        push_stat("pause_nop", 0, 1, 1);
        step = 1'b1;
        ctl(0, 0, 0);
        step = 1'b0;
      end
      prog_instr($urandom_range(0, 99) < load_pct, len);
      push_stat("retire", m_k == len, m_k != len, smode && m_k != len);
    end
    if (run) begin
      ctl(0, 0, 0);
      nop_exec();
      push_stat("done_nop", 1, 0, 1);
    end
    run = 1'b0;
    ctl(0, 0, 0);
    push_stat("idle", 0, 0, 1);
    ctl(0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned len;
    m_k = 0; m_ret = 0; m_err = 1'b0;
    @(posedge clk); #1;
    push_stat("reset", 0, 0, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) write_word(i, 10'($urandom));

    // LOAD R1 with operand 0x155
    write_word(0, 10'h040);
    write_word(1, 10'h155);
    run_prog(2, 0, 100, 0);
    // Single LOAD with its operand missing; mem[0] kept through the dropped write
    run_prog(1, 0, 100, 0);
    // Two one-word instructions, DRAIN after the second fetch
    write_word(0, 10'h008);
    write_word(1, 10'h048);
    run_prog(2, 0, 0, 0);
    // Single-step through two instructions
    run_prog(2, 1, 0, 0);

    // Asynchronous reset in the middle of a run
    m_k = 0; m_ret = 0; m_err = 1'b0;
    prog_len = 5'd4; step_en = 1'b0; run = 1'b1;
    ctl(0, 0, 0);
    run = 1'b0;
    prog_instr(0, 4);
    prog_instr(0, 4);
    exp_q.push_back(model_mem[m_k]);
    m_k++;
    ctl(1, 1, 0);
    push_stat("pre_reset", 0, 1, 0);
    @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    m_k = 0; m_ret = 0; m_err = 1'b0;
    push_stat("in_reset", 0, 0, 1);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_stat("after_reset", 0, 0, 1);
    ctl(0, 0, 0);

    // Randomised programs
    for (int r = 0; r < 30; r++) begin
      repeat ($urandom_range(0, 4)) write_word($urandom_range(0, DEPTH - 1), 10'($urandom));
      len = $urandom_range(0, DEPTH);
      run_prog(len, $urandom_range(0, 3) == 0, 40, 1);
    end

    repeat (2) @(negedge clk);
    fin = 1'b1;
    for (int i = 0; i < 10 && !fin_done; i++) @(posedge clk);
    if (!fin_done) begin
      $display("FAIL monitor: final drain check never ran");
      $fatal(1, "monitor stalled");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
